// File: rtl/fifo_1r1w_ctrl_pkg.sv
// Shared helpers for the 1R1W FIFO controller and its RAM.
// Holds only generic width helpers; no block-specific types live here.
package fifo_1r1w_ctrl_pkg;

  // Address width for a RAM of the given depth (at least one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port synchronous RAM: one write port, one read port,
// one-cycle read latency. The read data register holds its value until
// the next read, so an unconsumed word stays available at rdata_o.
module ram_1r1w_sync
  import fifo_1r1w_ctrl_pkg::*;
#(
  parameter  int unsigned DataWidth  = 8,
  parameter  int unsigned NumEntries = 512,
  localparam int unsigned AddrW      = addr_width(NumEntries)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 we_i,
  input  logic [AddrW-1:0]     waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrW-1:0]     raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] r_mem [NumEntries];
  logic [DataWidth-1:0] r_rdata;

  // Write port; array contents are not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, held between reads.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_rdata <= '0;
    end else if (re_i) begin
      r_rdata <= r_mem[raddr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/fifo_1r1w_ctrl.sv
// Valid/ready FIFO built on a 1R1W synchronous RAM plus a single output
// register driving valid_o/data_o. Occupancy counts RAM entries, the word
// in flight from the RAM read port, and the output register.
// Optional macro FIFO_1R1W_CTRL_BYPASS_EN: a write arriving while the RAM
// is empty, nothing is in flight and the output register can take a word
// goes straight into the output register instead of the RAM.
module fifo_1r1w_ctrl
  import fifo_1r1w_ctrl_pkg::*;
#(
  parameter  int unsigned Width = 8,
  parameter  int unsigned Depth = 512,
  localparam int unsigned CntW  = cnt_width(Depth)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  input  logic             ready_i,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned AddrW = addr_width(Depth);

  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic             r_inflight;
  logic             r_valid;
  logic [Width-1:0] r_data;
  logic [CntW-1:0]  r_count;
  logic             r_ready;

  logic             w_accept;
  logic             w_deliver;
  logic             w_ram_ne;
  logic             w_out_free;
  logic             w_load;
  logic             w_bypass;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [Width-1:0] w_rdata;
  logic [CntW-1:0]  w_count_nxt;

  ram_1r1w_sync #(
    .DataWidth  (Width),
    .NumEntries (Depth)
  ) u_ram (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (w_wr_en),
    .waddr_i (r_wr_ptr),
    .wdata_i (data_i),
    .re_i    (w_rd_en),
    .raddr_i (r_rd_ptr),
    .rdata_o (w_rdata)
  );

  // Handshakes, read scheduling and next occupancy.
  always_comb begin
    w_accept   = valid_i && r_ready;
    w_deliver  = r_valid && ready_i;
    // Read pointer never equals write pointer while words are stored, so a
    // read is never issued to the address being written this cycle.
    w_ram_ne   = (r_rd_ptr != r_wr_ptr);
    // Output register can take a word at this edge: empty or being drained.
    w_out_free = !r_valid || ready_i;
    // In-flight word moves into the output register once it is free;
    // otherwise it waits in the RAM read register.
    w_load     = r_inflight && w_out_free;
`ifdef FIFO_1R1W_CTRL_BYPASS_EN
    w_bypass   = w_accept && !w_ram_ne && !r_inflight && w_out_free;
`else
    w_bypass   = 1'b0;
`endif
    w_wr_en    = w_accept && !w_bypass;
    // A new read may start when the previous in-flight word is leaving
    // (w_load) or none is pending, which w_out_free covers in both cases.
    w_rd_en    = w_ram_ne && w_out_free;

    w_count_nxt = r_count;
    if (w_accept && !w_deliver) begin
      w_count_nxt = r_count + CntW'(1);
    end else if (!w_accept && w_deliver) begin
      w_count_nxt = r_count - CntW'(1);
    end
  end

  // Pointers, in-flight flag, occupancy and registered ready.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_ready    <= 1'b1;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AddrW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AddrW'(1);
      end
      if (w_rd_en) begin
        r_inflight <= 1'b1;
      end else if (w_load) begin
        r_inflight <= 1'b0;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < CntW'(Depth));
    end
  end

  // Output register: held while stalled, loaded from RAM or bypass.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_rdata;
    end else if (w_bypass) begin
      r_valid <= 1'b1;
      r_data  <= data_i;
    end else if (w_deliver) begin
      r_valid <= 1'b0;
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign count_o = r_count;

endmodule

// File: tb/tb_fifo_1r1w_ctrl.sv
// Self-checking bench for fifo_1r1w_ctrl (Width=8, Depth=4) against a
// queue-based reference model.
`timescale 1ns/1ps
module tb_fifo_1r1w_ctrl;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;
`ifdef FIFO_1R1W_CTRL_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic [W-1:0]  data_i;
  logic          ready_o;
  logic          valid_o;
  logic [W-1:0]  data_o;
  logic          ready_i;
  logic [CW-1:0] count_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start   = 0;
  int sent    = 0;
  bit found   = 1'b0;

  logic [W-1:0] mq[$];
  logic [W-1:0] cap[$];
  int           dcyc[$];

  fifo_1r1w_ctrl #(
    .Width (W),
    .Depth (D)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: update the model from the pre-edge handshake, then check.
  task automatic tick();
    bit acc;
    bit dlv;
    bit stall;
    logic [W-1:0] d;
    acc   = reset_i && valid_i && (mq.size() < D);
    dlv   = reset_i && (valid_o === 1'b1) && ready_i;
    stall = reset_i && (valid_o === 1'b1) && !ready_i;
    d     = data_i;
    if (dlv) begin
      if (mq.size() == 0) check("spurious_out", 32'(valid_o), 0);
      else void'(mq.pop_front());
    end
    @(posedge clk_i);
    #1;
    cyc++;
    if (!reset_i) mq.delete();
    else if (acc) mq.push_back(d);
    check("count", 32'(count_o), 32'(mq.size()));
    check("ready", 32'(ready_o), 32'(mq.size() < D));
    if (stall) check("hold_valid", 32'(valid_o), 1);
    if (mq.size() == 0) check("valid_empty", 32'(valid_o), 0);
    else if (valid_o === 1'b1) check("head_data", 32'(data_o), 32'(mq[0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    tick();
    tick();
    check("rst_valid", 32'(valid_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_ready", 32'(ready_o), 1);
    check("rst_data",  32'(data_o),  0);
    reset_i = 1'b1;
    tick();

    // Single word into an empty FIFO: latency and final count.
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'hA5;
    tick();
    valid_i = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      check("lat_valid", 32'(valid_o), 32'(k == LAT));
      if (k < LAT) tick();
    end
    check("lat_data", 32'(data_o), 32'h0000_00A5);
    tick();
    check("lat_count_after", 32'(count_o), 0);

    // Fill to capacity with the consumer stalled, then drain in order.
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      valid_i = 1'b1;
      data_i  = W'(i);
      tick();
    end
    check("full_ready", 32'(ready_o), 0);
    check("full_count", 32'(count_o), 4);
    data_i = 8'h05;
    tick();
    check("full_ignore_count", 32'(count_o), 4);
    valid_i = 1'b0;
    ready_i = 1'b1;
    cap.delete();
    for (int t = 0; t < 40 && cap.size() < 5; t++) begin
      if (valid_o === 1'b1) cap.push_back(data_o);
      tick();
    end
    check("drain_n", 32'(cap.size()), 4);
    for (int i = 0; i < cap.size(); i++) check("drain_order", 32'(cap[i]), 32'(i + 1));

    // Continuous streaming of 20 words: no gaps, steady count, wraps.
    cap.delete();
    dcyc.delete();
    ready_i = 1'b1;
    start   = cyc;
    for (int i = 0; i < 20; i++) begin
      valid_i = 1'b1;
      data_i  = W'(i);
      if (valid_o === 1'b1) begin
        cap.push_back(data_o);
        dcyc.push_back(cyc);
      end
      tick();
      if (i + 1 >= LAT) check("stream_count", 32'(count_o), 32'(LAT));
    end
    valid_i = 1'b0;
    for (int t = 0; t < 20 && cap.size() < 20; t++) begin
      if (valid_o === 1'b1) begin
        cap.push_back(data_o);
        dcyc.push_back(cyc);
      end
      tick();
    end
    check("stream_n", 32'(cap.size()), 20);
    if (cap.size() > 0) begin
      check("stream_first_lat", 32'(dcyc[0] - start), 32'(LAT));
      check("stream_data", 32'(cap[0]), 0);
    end
    for (int i = 1; i < cap.size(); i++) begin
      check("stream_gap",  32'(dcyc[i] - dcyc[i-1]), 1);
      check("stream_data", 32'(cap[i]), 32'(i));
    end

    // Random traffic with random backpressure, 1000 words.
    sent = 0;
    for (int t = 0; t < 20000 && !(sent >= 1000 && mq.size() == 0); t++) begin
      if (sent < 1000) begin
        valid_i = ($urandom_range(0, 99) < 70);
        data_i  = W'($urandom);
      end else begin
        valid_i = 1'b0;
      end
      ready_i = ($urandom_range(0, 99) < 50);
      if (valid_i && mq.size() < D) sent++;
      tick();
    end
    check("rand_sent", 32'(sent), 1000);
    check("rand_drained", 32'(mq.size()), 0);

    // Reset with three words held and a read in flight.
    valid_i = 1'b0;
    ready_i = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      data_i  = W'(8'hC0 + i);
      tick();
    end
    valid_i = 1'b0;
    check("pre_rst_count", 32'(count_o), 3);
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    check("rst2_valid", 32'(valid_o), 0);
    check("rst2_count", 32'(count_o), 0);
    check("rst2_ready", 32'(ready_o), 1);
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h5A;
    tick();
    valid_i = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (valid_o === 1'b1) begin
        check("rst2_first", 32'(data_o), 32'h0000_005A);
        found = 1'b1;
      end else begin
        tick();
      end
    end
    check("rst2_seen", 32'(found), 1);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
